// File: rtl/alu_pkg.sv
// Shared types and constants for the nibble-serial 74181 datapath.
package alu_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] S_ADD = 4'b1001;
  localparam logic [3:0] S_SUB = 4'b0110;
  localparam logic [3:0] S_XOR = 4'b0110;
  localparam logic [3:0] S_A   = 4'b0000;

  // A one-nibble datapath still needs a 1-bit index register.
  function automatic int idx_width(input int nib);
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/alu_74181.sv
// Combinational 4-bit 74181 slice: active-high data, cn/cn4 low means carry.
module alu_74181 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic [3:0] i_s,
  input  logic       i_m,
  input  logic       i_cn,
  output logic [3:0] o_f,
  output logic       o_cn4,
  output logic       o_aeqb
);

  logic [3:0] w_x;
  logic [3:0] w_y;
  logic [4:0] w_sum;

  // Every arithmetic entry of the function table is X plus Y; logic mode is XNOR(X, Y).
  assign w_x   = i_a | (i_b & {4{i_s[0]}}) | (~i_b & {4{i_s[1]}});
  assign w_y   = (i_a & ~i_b & {4{i_s[2]}}) | (i_a & i_b & {4{i_s[3]}});
  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {4'd0, ~i_cn};

  assign o_f    = i_m ? ~(w_x ^ w_y) : w_sum[3:0];
  assign o_cn4  = ~w_sum[4];
  assign o_aeqb = &o_f;

endmodule

// File: rtl/nibble_serial_alu.sv
// WIDTH-bit 74181 function computed one nibble per enabled cycle through a
// single slice, LSB nibble first, with a start/busy/done handshake.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             equal
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = idx_width(NIB);

  if (WIDTH < 4 || (WIDTH % 4) != 0) begin : g_widthCheck
    $error("nibble_serial_alu: WIDTH must be a positive multiple of 4");
  end

  state_t           r_state;
  state_t           w_nextState;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_s;
  logic             r_m;
  logic             r_carry;
  logic             r_eqAcc;
  logic [WIDTH-1:0] r_f;
  logic             r_cout;
  logic             r_equal;
  logic             r_done;

  logic             w_busy;
  logic             w_capture;
  logic             w_step;
  logic             w_last;
  logic [3:0]       w_nibA;
  logic [3:0]       w_nibB;
  logic [3:0]       w_sliceF;
  logic             w_sliceCn4;
  logic             w_sliceEq;

  assign w_nibA = r_a[int'(r_idx)*4 +: 4];
  assign w_nibB = r_b[int'(r_idx)*4 +: 4];

  alu_74181 u_slice (
    .i_a    (w_nibA),
    .i_b    (w_nibB),
    .i_s    (r_s),
    .i_m    (r_m),
    .i_cn   (r_carry),
    .o_f    (w_sliceF),
    .o_cn4  (w_sliceCn4),
    .o_aeqb (w_sliceEq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else if (ena) begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_nextState = RUN;
      RUN:     if (w_last) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_busy    = (r_state == RUN);
    w_capture = (r_state == IDLE) && start;
    w_step    = (r_state == RUN);
    w_last    = w_step && (r_idx == IW'(NIB - 1));
  end

  // Operands are snapshotted at start so the bus may change during the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_s     <= '0;
      r_m     <= 1'b0;
      r_carry <= 1'b1;
      r_eqAcc <= 1'b1;
      r_f     <= '0;
      r_cout  <= 1'b1;
      r_equal <= 1'b0;
      r_done  <= 1'b0;
    end else if (ena) begin
      if (w_capture) begin
        r_a     <= a;
        r_b     <= b;
        r_s     <= s;
        r_m     <= m;
        r_carry <= cn;
        r_idx   <= '0;
        r_eqAcc <= 1'b1;
      end
      if (w_step) begin
        r_f[int'(r_idx)*4 +: 4] <= w_sliceF;
        r_carry                 <= w_sliceCn4;
        r_eqAcc                 <= r_eqAcc & w_sliceEq;
        if (w_last) begin
          r_cout  <= w_sliceCn4;
          r_equal <= r_eqAcc & w_sliceEq;
          r_idx   <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
      r_done <= w_last;
    end
  end

  assign busy  = w_busy;
  assign done  = r_done;
  assign f     = r_f;
  assign cout  = r_cout;
  assign equal = r_equal;

endmodule

// File: tb/tb_nibble_serial_alu.sv
// Randomised self-checking bench for nibble_serial_alu against a full-width
// function-table model of the 74181; also exercises WIDTH=4 and WIDTH=32.
module tb_nibble_serial_alu;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst, ena, start, m, cn;
  logic [15:0] a, b;
  logic [3:0]  s;
  logic        busy, done, cout, equal;
  logic [15:0] f;

  logic        start4, busy4, done4, cout4, equal4;
  logic [3:0]  a4, b4, f4;
  logic        start32, busy32, done32, cout32, equal32;
  logic [31:0] a32, b32, f32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  nibble_serial_alu #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .a(a), .b(b), .s(s), .m(m), .cn(cn),
    .busy(busy), .done(done), .f(f), .cout(cout), .equal(equal)
  );

  nibble_serial_alu #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .ena(ena), .start(start4), .a(a4), .b(b4), .s(s), .m(m), .cn(cn),
    .busy(busy4), .done(done4), .f(f4), .cout(cout4), .equal(equal4)
  );

  nibble_serial_alu #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .ena(ena), .start(start32), .a(a32), .b(b32), .s(s), .m(m), .cn(cn),
    .busy(busy32), .done(done32), .f(f32), .cout(cout32), .equal(equal32)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Datasheet function table applied to whole words; "minus 1" entries add all ones.
  function automatic void refAlu(input longint unsigned ia, input longint unsigned ib,
                                 input logic [3:0] is, input logic im, input logic icn,
                                 input int w, output longint unsigned rf,
                                 output logic rc, output logic re);
    longint unsigned msk, aa, bb, nb, p, q, sum, lg;
    msk = (64'd1 << w) - 64'd1;
    aa  = ia & msk;
    bb  = ib & msk;
    nb  = ~bb & msk;
    case (is)
      4'd0:  begin p = aa;      q = 0;       lg = ~aa;         end
      4'd1:  begin p = aa | bb; q = 0;       lg = ~(aa | bb);  end
      4'd2:  begin p = aa | nb; q = 0;       lg = ~aa & bb;    end
      4'd3:  begin p = msk;     q = 0;       lg = 0;           end
      4'd4:  begin p = aa;      q = aa & nb; lg = ~(aa & bb);  end
      4'd5:  begin p = aa | bb; q = aa & nb; lg = ~bb;         end
      4'd6:  begin p = aa;      q = nb;      lg = aa ^ bb;     end
      4'd7:  begin p = aa & nb; q = msk;     lg = aa & nb;     end
      4'd8:  begin p = aa;      q = aa & bb; lg = ~aa | bb;    end
      4'd9:  begin p = aa;      q = bb;      lg = ~(aa ^ bb);  end
      4'd10: begin p = aa | nb; q = aa & bb; lg = bb;          end
      4'd11: begin p = aa & bb; q = msk;     lg = aa & bb;     end
      4'd12: begin p = aa;      q = aa;      lg = msk;         end
      4'd13: begin p = aa | bb; q = aa;      lg = aa | nb;     end
      4'd14: begin p = aa | nb; q = aa;      lg = aa | bb;     end
      default: begin p = aa;    q = msk;     lg = aa;          end
    endcase
    sum = p + q + {63'd0, ~icn};
    rf  = im ? (lg & msk) : (sum & msk);
    rc  = (((sum >> w) & 64'd1) == 64'd0);
    re  = (rf == msk);
  endfunction

  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic [3:0] ts,
                               input logic tm, input logic tcn, input bit stall, input bit repulse,
                               input string tag);
    longint unsigned ef;
    logic ec, ee;
    int edges, busyCnt, lat, extra;
    refAlu(64'(ta), 64'(tb), ts, tm, tcn, 16, ef, ec, ee);
    @(negedge clk);
    a = ta; b = tb; s = ts; m = tm; cn = tcn; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); s = 4'($urandom); m = 1'($urandom); cn = 1'($urandom);
    edges = 1;
    busyCnt = 0;
    while (done !== 1'b1 && edges < 40) begin
      if (busy === 1'b1) busyCnt++;
      start = repulse && (edges == 2);
      if (stall && edges == 3) ena = 1'b0;
      if (stall && edges == 5) checkOutput({tag, ".frozenDone"}, 64'(done), 64'(0));
      if (stall && edges == 6) ena = 1'b1;
      @(negedge clk);
      edges++;
    end
    start = 1'b0;
    lat = stall ? 8 : 5;
    checkOutput({tag, ".latency"}, 64'(edges), 64'(lat));
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(lat - 1));
    checkOutput({tag, ".f"}, 64'(f), ef);
    checkOutput({tag, ".cout"}, 64'(cout), 64'(ec));
    checkOutput({tag, ".equal"}, 64'(equal), 64'(ee));
    checkOutput({tag, ".busyAtDone"}, 64'(busy), 64'(0));
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 64'(done), 64'(0));
    if (repulse) begin
      extra = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checkOutput({tag, ".noRestart"}, 64'(extra), 64'(0));
    end
  endtask

  task automatic applyResetAbort();
    int seen;
    @(negedge clk);
    a = 16'h1234; b = 16'h0FFF; s = S_ADD; m = 1'b0; cn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort.busy", 64'(busy), 64'(0));
    checkOutput("abort.done", 64'(done), 64'(0));
    checkOutput("abort.f", 64'(f), 64'(0));
    checkOutput("abort.cout", 64'(cout), 64'(1));
    checkOutput("abort.equal", 64'(equal), 64'(0));
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checkOutput("abort.noDone", 64'(seen), 64'(0));
  endtask

  task automatic applyBackToBack();
    longint unsigned ef1, ef2;
    logic ec1, ee1, ec2, ee2;
    int edges;
    refAlu(64'h00FF, 64'h0001, S_ADD, 1'b0, 1'b1, 16, ef1, ec1, ee1);
    refAlu(64'hAAAA, 64'h5555, S_XOR, 1'b1, 1'b1, 16, ef2, ec2, ee2);
    @(negedge clk);
    a = 16'h00FF; b = 16'h0001; s = S_ADD; m = 1'b0; cn = 1'b1; start = 1'b1;
    @(negedge clk);
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("b2b.first.latency", 64'(edges), 64'(5));
    checkOutput("b2b.first.f", 64'(f), ef1);
    a = 16'hAAAA; b = 16'h5555; s = S_XOR; m = 1'b1; cn = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(negedge clk);
      edges++;
    end
    checkOutput("b2b.second.latency", 64'(edges), 64'(5));
    checkOutput("b2b.second.f", 64'(f), ef2);
    checkOutput("b2b.second.cout", 64'(cout), 64'(ec2));
    checkOutput("b2b.second.equal", 64'(equal), 64'(ee2));
  endtask

  task automatic runSmall(input logic [3:0] x4, input logic [3:0] y4, input logic [31:0] x32,
                          input logic [31:0] y32, input logic [3:0] ts, input logic tm,
                          input logic tcn, input string tag);
    longint unsigned ef4, ef32;
    logic ec4, ee4, ec32, ee32;
    logic [3:0] gf4;
    logic [31:0] gf32;
    logic gc4, ge4, gc32, ge32;
    int edges, at4, at32;
    refAlu(64'(x4), 64'(y4), ts, tm, tcn, 4, ef4, ec4, ee4);
    refAlu(64'(x32), 64'(y32), ts, tm, tcn, 32, ef32, ec32, ee32);
    gf4 = '0; gf32 = '0; gc4 = 1'b0; ge4 = 1'b0; gc32 = 1'b0; ge32 = 1'b0;
    @(negedge clk);
    a4 = x4; b4 = y4; a32 = x32; b32 = y32; s = ts; m = tm; cn = tcn;
    start4 = 1'b1; start32 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; start32 = 1'b0;
    edges = 1; at4 = 0; at32 = 0;
    while ((at4 == 0 || at32 == 0) && edges < 40) begin
      if (done4 === 1'b1 && at4 == 0) begin
        at4 = edges; gf4 = f4; gc4 = cout4; ge4 = equal4;
      end
      if (done32 === 1'b1 && at32 == 0) begin
        at32 = edges; gf32 = f32; gc32 = cout32; ge32 = equal32;
      end
      @(negedge clk);
      edges++;
    end
    checkOutput({tag, ".w4.latency"}, 64'(at4), 64'(2));
    checkOutput({tag, ".w4.f"}, 64'(gf4), ef4);
    checkOutput({tag, ".w4.cout"}, 64'(gc4), 64'(ec4));
    checkOutput({tag, ".w4.equal"}, 64'(ge4), 64'(ee4));
    checkOutput({tag, ".w32.latency"}, 64'(at32), 64'(9));
    checkOutput({tag, ".w32.f"}, 64'(gf32), ef32);
    checkOutput({tag, ".w32.cout"}, 64'(gc32), 64'(ec32));
    checkOutput({tag, ".w32.equal"}, 64'(ge32), 64'(ee32));
    checkOutput({tag, ".idle"}, 64'({busy4, busy32}), 64'(0));
  endtask

  function automatic logic [15:0] pickOperand();
    logic [15:0] corners [4];
    corners[0] = 16'h0000; corners[1] = 16'hFFFF; corners[2] = 16'h0001; corners[3] = 16'h8000;
    if ($urandom_range(3) == 0) return corners[$urandom_range(3)];
    return 16'($urandom);
  endfunction

  initial begin
    logic [15:0] ra, rb;
    rst = 1'b1; ena = 1'b1; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cn = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; start32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset.busy", 64'(busy), 64'(0));
    checkOutput("reset.done", 64'(done), 64'(0));
    checkOutput("reset.f", 64'(f), 64'(0));
    checkOutput("reset.cout", 64'(cout), 64'(1));
    checkOutput("reset.equal", 64'(equal), 64'(0));
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 1'b0, 1'b0, "add");
    checkOutput("add.literal", 64'(f), 64'h2233);
    applyStimulus(16'hFFFF, 16'h0001, S_ADD, 1'b0, 1'b1, 1'b0, 1'b0, "ripple");
    checkOutput("ripple.literal", 64'({cout, f}), 64'h0_0000);
    applyStimulus(16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b1, 1'b0, 1'b0, "subEq");
    checkOutput("subEq.literal", 64'({equal, f}), 64'h1_FFFF);
    applyStimulus(16'h5A5A, 16'h5A5A, S_SUB, 1'b0, 1'b0, 1'b0, 1'b0, "subBorrow");
    checkOutput("subBorrow.literal", 64'({equal, cout, f}), 64'h0_0000);
    applyStimulus(16'hF0F0, 16'hFF00, S_XOR, 1'b1, 1'b1, 1'b0, 1'b1, "xor");
    checkOutput("xor.literal", 64'(f), 64'h0FF0);
    applyStimulus(16'h1234, 16'h0FFF, S_ADD, 1'b0, 1'b1, 1'b1, 1'b0, "stall");
    applyStimulus(16'h00F0, 16'hABCD, S_A, 1'b1, 1'b0, 1'b0, 1'b0, "logicA");

    applyResetAbort();
    applyBackToBack();

    runSmall(4'h9, 4'h8, 32'hFFFF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, "wide.add");
    checkOutput("wide.add.literal4", 64'({cout4, f4}), 64'h01);
    checkOutput("wide.add.literal32", 64'({cout32, f32}), 64'h0);
    for (int i = 0; i < 3; i++) begin
      runSmall(4'($urandom), 4'($urandom), 32'($urandom), 32'($urandom),
               4'($urandom), 1'($urandom), 1'($urandom), "wide.rand");
    end

    for (int i = 0; i < 24; i++) begin
      ra = pickOperand();
      rb = ($urandom_range(3) == 0) ? ra : pickOperand();
      applyStimulus(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(4) == 0), ($urandom_range(4) == 0), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
